idp_enc_seq_23: RTL and testbench
=================================

// Module: idp_enc_seq_23
// PURPOSE
// - Transmit-side counterpart of the 23-bit IDP decoder: converts a binary word into a
//   23-bit Fibonacci-numeral-system (FNS) codeword, one bit per cycle, MSB first.
// - Uses the greedy (Zeckendorf) algorithm, so no two adjacent code bits are set.
// - Sits between the data source (valid/ready) and the bus driver.
// - The receive-side IDP decoder reproduces the input word exactly.
// PARAMETERS
// - CW  23  codeword width; fixed to 23, matching the FNS.vh weight set.
// - DW  17  data width (`IBLEN23); must hold MAXV = 75024.
// PORTS
// - clk        in   1   clock; all state updates on the rising edge.
// - rst_n      in   1   reset, asynchronous assert, active-low.
// - in_valid   in   1   source has a word on in_data.
// - in_ready   out  1   block can accept a word.
// - in_data    in   DW  binary word to encode.
// - out_valid  out  1   out_code and out_err are valid.
// - out_ready  in   1   sink accepts the codeword.
// - out_code   out  CW  FNS codeword; bit k has weight W(k).
// - out_err    out  1   input was over range; out_code is all zeros.
// BEHAVIOUR
// - Weights: W(k) = F(k+1) with F(1)=1, F(2)=2, F(n)=F(n-1)+F(n-2).
//   W(0)=1, W(1)=2, ..., W(22)=46368. MAXV = F(24)-1 = 75024.
// - Reset (rst_n=0): state IDLE; in_ready=0, out_valid=0, out_code=0, out_err=0,
//   residue=0, idx=0. After release, in_ready=1 from the first clock edge.
// - Reset during ENC or HOLD aborts the word: nothing is emitted and the word is lost.
// - FSM IDLE -> ENC -> HOLD -> IDLE. in_ready = (state==IDLE); there is no skid buffer.
// - IDLE, accept edge (in_valid & in_ready):
//   - in_data > MAXV: out_code=0, out_err=1, go to HOLD.
//     out_valid is visible 1 cycle after the accept edge.
//   - Otherwise: residue=in_data, idx=22, out_code=0, out_err=0, go to ENC.
// - ENC, each edge: if residue >= W(idx), set out_code[idx]=1 and residue -= W(idx);
//   else out_code[idx]=0. Then idx -= 1.
//   - Step with idx==0: go to HOLD.
//   - Compare and subtract are DW bits wide; residue never underflows.
// - Latency: without the feature, out_valid rises 23 cycles after the accept edge.
// - HOLD: out_valid=1. out_code and out_err stay stable until out_valid & out_ready.
//   On that edge: out_valid=0, go to IDLE. The next accept is possible 1 cycle later.
//   out_code keeps its last value while out_valid=0.
// - Invariants: out_code & (out_code>>1) == 0. Weighted sum of out_code == in_data.
// - in_data and in_valid are ignored outside IDLE.
// - out_ready is ignored outside HOLD.
// CONFIGURATION
// - Macro IDP_ENC_EARLY_DONE_EN.
//   - Defined: in ENC, if the step makes the new residue zero, go to HOLD on that edge.
//     Bits idx-1..0 stay 0. Latency = 23 - (lowest set bit index) cycles, minimum 1.
//     An input of 0 takes 1 cycle.
//   - Undefined: latency is always 23 cycles; zero residue has no special handling.
//   - out_code and out_err are identical in both builds.
// TESTING
// - in_data=0 -> out_code=23'h000000, out_err=0; out_valid after 23 cycles (1 with EARLY_DONE).
// - in_data=75024 -> out_code=23'h555555, out_err=0; out_valid after 23 cycles in both builds.
// - in_data=75025 -> out_code=0, out_err=1; out_valid 1 cycle after accept; in_ready=0 in HOLD.
// - in_data=100 -> out_code=23'h000214 (89+8+3); 23 cycles, or 21 with EARLY_DONE.
// - After in_data=100, hold out_ready=0 for 10 cycles -> out_valid=1, out_code=23'h000214
//   stable, in_ready=0; out_ready=1 -> IDLE next cycle.
// - Pulse rst_n=0 at ENC idx=10 -> all outputs 0 at once; after release, in_data=1 encodes
//   to 23'h000001. Then 2000 random words in [0,75024] through the IDP decoder -> round trip.

Source files
------------

// File: rtl/idp_enc_seq_23.sv
// Greedy Zeckendorf encoder: binary word -> 23-bit FNS codeword, one bit per cycle, MSB first.
// Optional early finish when the residue reaches zero: define IDP_ENC_EARLY_DONE_EN.
module idp_enc_seq_23 #(
  parameter int CW = 23,
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_code,
  output logic          out_err
);

  localparam logic [DW-1:0] MAXV = DW'(75024);

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    HOLD
  } state_t;

  state_t        state;
  logic [DW-1:0] residue;
  logic [4:0]    idx;
  logic [DW-1:0] w;
  logic          take;
  logic [DW-1:0] nres;
  logic          done;

  // W(k) = F(k+1), F(1)=1, F(2)=2
  function automatic logic [DW-1:0] wt(input logic [4:0] k);
    logic [31:0] a, b, t, r;
    a = 32'd1;
    b = 32'd2;
    r = 32'd0;
    for (int i = 0; i < CW; i++) begin
      if (k == 5'(i)) r = a;
      t = a + b;
      a = b;
      b = t;
    end
    return DW'(r);
  endfunction

  always_comb begin
    w    = wt(idx);
    take = (residue >= w);
    nres = take ? (residue - w) : residue;
`ifdef IDP_ENC_EARLY_DONE_EN
    done = (idx == 5'd0) || (nres == '0);
`else
    done = (idx == 5'd0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_err   <= 1'b0;
      residue   <= '0;
      idx       <= 5'd0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            out_code <= '0;
            if (in_data > MAXV) begin
              // out_valid follows one cycle later
              out_err <= 1'b1;
              state   <= HOLD;
            end else begin
              out_err <= 1'b0;
              residue <= in_data;
              idx     <= 5'd22;
              state   <= ENC;
            end
          end
        end
        ENC: begin
          if (take) out_code <= out_code | (CW'(1) << idx);
          residue <= nres;
          if (idx != 5'd0) idx <= idx - 5'd1;
          if (done) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idp_enc_seq_23.sv
// Directed and round-trip bench for idp_enc_seq_23.
// Latency expectations follow IDP_ENC_EARLY_DONE_EN.
module tb_idp_enc_seq_23;

`ifdef IDP_ENC_EARLY_DONE_EN
  localparam int LAT0   = 1;
  localparam int LAT100 = 21;
`else
  localparam int LAT0   = 23;
  localparam int LAT100 = 23;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_code;
  logic        out_err;

  int pass;
  int total;
  int wts[23];

  idp_enc_seq_23 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code (out_code),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_word(input logic [16:0] d, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 17'h0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 17'h0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, out_err, out_code} !== 26'h0)
      $display("FAIL reset_outputs got rdy=%b vld=%b err=%b code=%h want all 0",
               in_ready, out_valid, out_err, out_code);
    else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL ready_before_edge got %b want 0", in_ready);
    else pass++;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL ready_after_edge got %b want 1", in_ready);
    else pass++;
  endtask

  task automatic test_zero();
    int lat;
    drive_word(17'd0, lat);
    total++;
    if (lat != LAT0) $display("FAIL zero_latency got %0d want %0d", lat, LAT0);
    else pass++;
    total++;
    if ({out_err, out_code} !== 24'h0)
      $display("FAIL zero_code got err=%b code=%h want err=0 code=000000", out_err, out_code);
    else pass++;
    release_out();
  endtask

  task automatic test_max();
    int lat;
    drive_word(17'd75024, lat);
    total++;
    if (lat != 23) $display("FAIL max_latency got %0d want 23", lat);
    else pass++;
    total++;
    if ({out_err, out_code} !== {1'b0, 23'h555555})
      $display("FAIL max_code got err=%b code=%h want err=0 code=555555", out_err, out_code);
    else pass++;
    release_out();
  endtask

  task automatic test_over();
    int lat;
    drive_word(17'd75025, lat);
    total++;
    if (lat != 1) $display("FAIL over_latency got %0d want 1", lat);
    else pass++;
    total++;
    if ({out_err, out_code, in_ready} !== {1'b1, 23'h0, 1'b0})
      $display("FAIL over_code got err=%b code=%h rdy=%b want err=1 code=000000 rdy=0",
               out_err, out_code, in_ready);
    else pass++;
    release_out();
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL over_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    else pass++;
  endtask

  task automatic test_hold();
    int lat;
    drive_word(17'd100, lat);
    total++;
    if (lat != LAT100) $display("FAIL h100_latency got %0d want %0d", lat, LAT100);
    else pass++;
    total++;
    if ({out_err, out_code} !== {1'b0, 23'h000214})
      $display("FAIL h100_code got err=%b code=%h want err=0 code=000214", out_err, out_code);
    else pass++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({out_valid, in_ready, out_code} !== {2'b10, 23'h000214})
        $display("FAIL h100_stall%0d got vld=%b rdy=%b code=%h want vld=1 rdy=0 code=000214",
                 i, out_valid, in_ready, out_code);
      else pass++;
    end
    release_out();
    total++;
    if ({out_valid, in_ready, out_code} !== {2'b01, 23'h000214})
      $display("FAIL h100_release got vld=%b rdy=%b code=%h want vld=0 rdy=1 code=000214",
               out_valid, in_ready, out_code);
    else pass++;
  endtask

  task automatic test_abort();
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 17'd75024;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // after 12 steps the next bit index is 10
    repeat (12) @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b00)
      $display("FAIL abort_midenc got vld=%b rdy=%b want 0 0", out_valid, in_ready);
    else pass++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_err, out_code} !== 26'h0)
      $display("FAIL abort_reset got rdy=%b vld=%b err=%b code=%h want all 0",
               in_ready, out_valid, out_err, out_code);
    else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    drive_word(17'd1, lat);
    total++;
    if (lat != 23 || {out_err, out_code} !== {1'b0, 23'h000001})
      $display("FAIL abort_next got lat=%0d err=%b code=%h want lat=23 err=0 code=000001",
               lat, out_err, out_code);
    else pass++;
    release_out();
  endtask

  task automatic test_round_trip();
    int lat;
    int d;
    int sum;
    logic [22:0] adj;
    for (int n = 0; n < 2000; n++) begin
      d = int'($urandom_range(75024, 0));
      drive_word(17'(d), lat);
      sum = 0;
      for (int k = 0; k < 23; k++)
        if (out_code[k]) sum += wts[k];
      adj = out_code & (out_code >> 1);
      total++;
      if (lat < 0 || sum != d || adj != 23'h0 || out_err !== 1'b0)
        $display("FAIL rt%0d got lat=%0d dec=%0d adj=%h err=%b want dec=%0d adj=0 err=0",
                 n, lat, sum, adj, out_err, d);
      else pass++;
      release_out();
    end
  endtask

  initial begin
    pass = 0;
    total = 0;
    wts[0] = 1;
    wts[1] = 2;
    for (int k = 2; k < 23; k++) wts[k] = wts[k-1] + wts[k-2];
    test_reset();
    test_zero();
    test_max();
    test_over();
    test_hold();
    test_abort();
    test_round_trip();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
